// File: rtl/mainfsm_mc.sv
// Multicycle ARM main controller: sequences fetch/decode/execute/memory/writeback
// with memory wait-states, a multi-cycle multiply state and a branch-with-link path.
module mainfsm_mc #(
    parameter int MUL_CYCLES    = 4,
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       IsMul,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       MulEn,
    output logic       LinkW,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10,
        EXECUTEM = 4'd11,
        LINK     = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic       rdy;
    logic       cnt_last;
    logic       unused_funct;

    // Handshake: memory raises MemReady in the cycle the access completes; the
    // FSM holds in FETCH/MEMRD/MEMWR until then and ignores MemReady elsewhere.
    assign rdy          = (USE_MEM_READY != 0) ? MemReady : 1'b1;
    assign cnt_last     = (cnt_q == 4'(MUL_CYCLES - 1));
    assign unused_funct = ^Funct[3:1];
    assign State        = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            if (state_q == EXECUTEM && !cnt_last)
                cnt_q <= cnt_q + 4'd1;
            else
                cnt_q <= 4'd0;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = rdy ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00: begin
                        if (Funct[5])   state_d = EXECUTEI;
                        else if (IsMul) state_d = EXECUTEM;
                        else            state_d = EXECUTER;
                    end
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = Funct[4] ? LINK : BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            EXECUTEM: state_d = cnt_last ? ALUWB : EXECUTEM;
            MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_d = rdy ? MEMWB : MEMRD;
            MEMWR:    state_d = rdy ? FETCH : MEMWR;
            LINK:     state_d = BRANCH;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        MulEn     = 1'b0;
        LinkW     = 1'b0;
        Illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                NextPC    = rdy;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            EXECUTER: ALUOp = 1'b1;
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            EXECUTEM: begin
                ALUOp = 1'b1;
                MulEn = 1'b1;
            end
            ALUWB:  RegW = 1'b1;
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = 2'b01;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = rdy;
            end
            LINK: begin
                RegW      = 1'b1;
                LinkW     = 1'b1;
                ResultSrc = 2'b11;
            end
            BRANCH: begin
                Branch    = 1'b1;
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
            end
            UNKNOWN: Illegal = 1'b1;
            default: ;
        endcase
        // Enables must stay quiet while reset is held, whatever the state.
        if (reset) begin
            IRWrite = 1'b0;
            NextPC  = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            Branch  = 1'b0;
            MulEn   = 1'b0;
            LinkW   = 1'b0;
            Illegal = 1'b0;
        end
    end

endmodule
